instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/imm_pack.sv | 46 ++++
 rtl/instr_encoder.sv | 171 +++++++++++++++++
 tb/tb_instr_encoder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoder definitions: instruction formats, error codes, FSM states
// and the sign-extension range test used by the immediate packer.
package riscv_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_R = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_IS_RANGE = 2'b01,
    ERR_B_RANGE  = 2'b10,
    ERR_B_ODD    = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_ERROR = 2'b11
  } state_e;

  localparam logic [31:0] ADDR_STEP      = 32'd4;
  localparam logic [15:0] WORD_COUNT_MAX = 16'hFFFF;

  // True when imm is a sign extension of its low 12 bits (I/S) or 13 bits (B).
  function automatic logic imm_fits(input logic [31:0] imm, input logic b_range);
    if (b_range) begin
      return (&imm[31:12]) || !(|imm[31:12]);
    end
    return (&imm[31:11]) || !(|imm[31:11]);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational instruction packer: assembles the 32-bit word for the selected
// format and flags immediates that cannot be represented.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err,
  output logic        odd_err
);

  fmt_e fmt_c;
  assign fmt_c = fmt_e'(fmt);

  always_comb begin
    word      = '0;
    range_err = 1'b0;
    odd_err   = 1'b0;
    case (fmt_c)
      FMT_I: begin
        word      = {imm[11:0], rs1, funct3, rd, opcode};
        range_err = !imm_fits(imm, 1'b0);
      end
      FMT_S: begin
        word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_err = !imm_fits(imm, 1'b0);
      end
      FMT_B: begin
        word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_err = !imm_fits(imm, 1'b1);
        odd_err   = imm[0];
      end
      default: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: accepts decoded fields, emits encoded words with
// sequential byte addresses, and stops on the first unrepresentable immediate.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] word_count
);

  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  err_code_e   err_code_q, err_code_d;
  logic [15:0] word_count_q, word_count_d;
  logic        orphan_q, orphan_d;

  logic [31:0] pack_word;
  logic        range_err, odd_err;
  logic        in_ready_c, in_fire, out_fire;
  logic        base_lsb_unused;

  assign base_lsb_unused = ^base_addr[1:0];

  imm_pack u_imm_pack (
    .fmt       (fmt),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .word      (pack_word),
    .range_err (range_err),
    .odd_err   (odd_err)
  );

  assign in_ready_c = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign in_fire    = in_valid && in_ready_c;
  assign out_fire   = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;
    err_d        = err_q;
    err_code_d   = err_code_q;
    word_count_d = word_count_q;
    orphan_d     = orphan_q;

    // A word left over from a load that was restarted must not advance the new load.
    if (out_fire) begin
      out_valid_d = 1'b0;
      orphan_d    = 1'b0;
      if (!orphan_q) begin
        ptr_d = ptr_q + ADDR_STEP;
        if (word_count_q != WORD_COUNT_MAX) begin
          word_count_d = word_count_q + 16'd1;
        end
      end
    end

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          ptr_d        = {base_addr[31:2], 2'b00};
          err_d        = 1'b0;
          err_code_d   = ERR_NONE;
          word_count_d = '0;
          orphan_d     = out_valid_q && !out_fire;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_fire) begin
          if (odd_err || range_err) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
            if (odd_err) begin
              err_code_d = ERR_B_ODD;
            end else if (fmt_e'(fmt) == FMT_B) begin
              err_code_d = ERR_B_RANGE;
            end else begin
              err_code_d = ERR_IS_RANGE;
            end
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = pack_word;
            out_addr_d  = ptr_d;
            if (in_last) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      word_count_q <= '0;
      orphan_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      word_count_q <= word_count_d;
      orphan_q     <= orphan_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized loads
// checked against a format-level reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr, out_data;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] word_count;

  int tests = 0;
  int fails = 0;
  int ready_mode = 1;   // 0 low, 1 high, 2 random
  int done_cnt = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] mdl_ptr;
  int          mdl_err;
  int          bnd[8] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 4095};

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_addr, out_data});
    if (done) done_cnt++;
  end

  // Reference encoding straight from the format field layouts.
  function automatic logic [31:0] ref_word(input int f, input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rd_,
                                           input logic [4:0] rs1_, input logic [4:0] rs2_,
                                           input logic [31:0] im);
    logic [31:0] w;
    w = (32'(rs1_) << 15) | (32'(f3) << 12) | 32'(op);
    case (f)
      0: w = w | ((im & 32'hFFF) << 20) | (32'(rd_) << 7);
      1: w = w | (((im >> 5) & 32'h7F) << 25) | (32'(rs2_) << 20) | ((im & 32'h1F) << 7);
      2: w = w | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(rs2_) << 20)
               | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
      default: w = w | (32'(f7) << 25) | (32'(rs2_) << 20) | (32'(rd_) << 7);
    endcase
    return w;
  endfunction

  function automatic int ref_err(input int f, input logic [31:0] im);
    int s;
    s = $signed(im);
    if (f == 3) return 0;
    if (f == 2) begin
      if ((s % 2) != 0) return 3;
      if (s < -4096 || s > 4095) return 2;
      return 0;
    end
    if (s < -2048 || s > 2047) return 1;
    return 0;
  endfunction

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    mdl_ptr = {b[31:2], 2'b00};
    mdl_err = 0;
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic present(input int f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd_, input logic [4:0] rs1_, input logic [4:0] rs2_,
                         input logic [31:0] im, input logic last);
    int e;
    fmt = 2'(f); opcode = op; funct3 = f3; funct7 = f7;
    rd = rd_; rs1 = rs1_; rs2 = rs2_; imm = im; in_last = last;
    in_valid = 1'b1;
    e = ref_err(f, im);
    if (e == 0) begin
      exp_q.push_back({mdl_ptr, ref_word(f, op, f3, f7, rd_, rs1_, rs2_, im)});
      mdl_ptr = mdl_ptr + 32'd4;
    end else begin
      mdl_err = e;
    end
    $display("[TB] word fmt=%0d imm=%0d last=%0d expect_err=%0d", f, $signed(im), last, e);
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send(input int f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd_, input logic [4:0] rs1_, input logic [4:0] rs2_,
                      input logic [31:0] im, input logic last);
    present(f, op, f3, f7, rd_, rs1_, rs2_, im, last);
    wait_accept();
  endtask

  task automatic wait_finish();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy && !out_valid) break;
      n++;
      if (n > 500) begin
        tests++; fails++;
        $display("FAIL finish_timeout: busy=%b out_valid=%b, required 0/0", busy, out_valid);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_results(input string name, input int exp_done);
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL %s word_total: got %0d words, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s word%0d: got %h, required %h", name, i,
                 (i < got_q.size()) ? got_q[i] : 64'hX, exp_q[i]);
      end
    end
    tests++;
    if (done_cnt !== exp_done) begin
      fails++;
      $display("FAIL %s done_pulses: got %0d, required %0d", name, done_cnt, exp_done);
    end
    tests++;
    if (word_count !== 16'(exp_q.size())) begin
      fails++;
      $display("FAIL %s word_count: got %0d, required %0d", name, word_count, exp_q.size());
    end
    tests++;
    if (err !== (mdl_err != 0) || err_code !== 2'(mdl_err)) begin
      fails++;
      $display("FAIL %s err: got err=%b code=%b, required err=%b code=%b", name, err, err_code,
               (mdl_err != 0), 2'(mdl_err));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    fmt = '0; opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, out_valid, busy, done, err} !== 5'b0 || err_code !== 2'b0) begin
      fails++;
      $display("FAIL reset_flags: got rdy/vld/busy/done/err=%b code=%b, required 0", 
               {in_ready, out_valid, busy, done, err}, err_code);
    end
    tests++;
    if (out_addr !== 32'h0 || out_data !== 32'h0 || word_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_regs: got addr=%h data=%h cnt=%h, required 0", out_addr, out_data, word_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got in_ready=%b busy=%b, required 0/0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    logic [63:0] want[3];
    want[0] = {32'h0000_0100, 32'hFFC1_2283};
    want[1] = {32'h0000_0104, 32'h0061_2423};
    want[2] = {32'h0000_0108, 32'h0020_8863};
    ready_mode = 1;
    do_start(32'h100);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    send(0, 7'h03, 3'd2, 7'd0, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b0);
    send(1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd6, 32'd8, 1'b0);
    send(2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd16, 1'b1);
    wait_finish();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== want[i]) begin
        fails++;
        $display("FAIL directed_word%0d: got %h, required %h", i,
                 (i < got_q.size()) ? got_q[i] : 64'hX, want[i]);
      end
    end
    check_results("directed", 1);
  endtask

  task automatic test_errors();
    int leaked = 0;
    ready_mode = 1;
    do_start(32'h200);
    send(3, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    send(2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    wait_finish();
    tests++;
    if (got_q.size() < 1 || got_q[0][31:0] !== 32'h0020_81B3) begin
      fails++;
      $display("FAIL r_add: got %h, required 002081b3", (got_q.size() > 0) ? got_q[0][31:0] : 32'hX);
    end
    tests++;
    if (err !== 1'b1 || err_code !== 2'b11 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b_odd: got err=%b code=%b busy=%b, required 1/11/0", err, err_code, busy);
    end
    check_results("b_odd", 0);
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (in_ready) leaked++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (leaked != 0) begin
      fails++;
      $display("FAIL error_holds: in_ready high %0d cycles in error, required 0", leaked);
    end
    do_start(32'h300);
    tests++;
    if (err !== 1'b0 || err_code !== 2'b00) begin
      fails++;
      $display("FAIL err_clear: got err=%b code=%b, required 0/00", err, err_code);
    end
    send(0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd2048, 1'b1);
    wait_finish();
    check_results("i_range", 0);
    do_start(32'h300);
    send(2, 7'h63, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, 32'd4096, 1'b1);
    wait_finish();
    check_results("b_range", 0);
    do_start(32'h300);
    send(2, 7'h63, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, 32'd4097, 1'b1);
    wait_finish();
    check_results("b_odd_prec", 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int bad = 0;
    ready_mode = 0;
    do_start(32'h400);
    send(0, 7'h13, 3'd0, 7'd0, 5'd7, 5'd8, 5'd0, 32'd100, 1'b0);
    held = exp_q[0][31:0];
    present(1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd9, 5'd10, -32'sd20, 1'b1);
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL backpressure_hold: %0d bad cycles (rdy=%b vld=%b data=%h), required data %h",
               bad, in_ready, out_valid, out_data, held);
    end
    @(posedge clk); #1;
    ready_mode = 1;
    wait_accept();
    wait_finish();
    check_results("backpressure", 1);
  endtask

  task automatic test_wrap();
    ready_mode = 1;
    do_start(32'hFFFF_FFFC);
    send(3, 7'h33, 3'd7, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(0, 7'h13, 3'd0, 7'd0, 5'd4, 5'd5, 5'd0, -32'sd2048, 1'b1);
    wait_finish();
    tests++;
    if (got_q.size() != 2 || got_q[0][63:32] !== 32'hFFFF_FFFC || got_q[1][63:32] !== 32'h0) begin
      fails++;
      $display("FAIL wrap_addr: got %0d words, first addr %h, required fffffffc then 00000000",
               got_q.size(), (got_q.size() > 0) ? got_q[0][63:32] : 32'hX);
    end
    check_results("wrap", 1);
  endtask

  task automatic test_reset_midload();
    int acc = 0;
    ready_mode = 0;
    do_start(32'h500);
    send(0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
    present(0, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'd2, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, busy, done, err} !== 5'b0 || out_addr !== 32'h0 ||
        out_data !== 32'h0 || word_count !== 16'h0) begin
      fails++;
      $display("FAIL midload_reset: got flags=%b addr=%h data=%h cnt=%h, required 0",
               {in_ready, out_valid, busy, done, err}, out_addr, out_data, word_count);
    end
    got_q.delete();
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 1;
    repeat (10) begin
      @(negedge clk);
      if (in_ready) acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    tests++;
    if (acc != 0 || got_q.size() != 0 || done_cnt != 0) begin
      fails++;
      $display("FAIL no_accept_before_start: ready cycles=%0d words=%0d done=%0d, required 0",
               acc, got_q.size(), done_cnt);
    end
    do_start(32'h600);
    send(3, 7'h33, 3'd0, 7'd0, 5'd9, 5'd8, 5'd7, 32'd0, 1'b1);
    wait_finish();
    check_results("after_reset", 1);
  endtask

  task automatic test_random();
    int n, f, pick, e;
    logic [31:0] im;
    ready_mode = 2;
    for (int ld = 0; ld < 20; ld++) begin
      do_start($urandom());
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        f = $urandom_range(0, 3);
        pick = $urandom_range(0, 5);
        if (pick == 0)      im = 32'(bnd[$urandom_range(0, 7)]);
        else if (pick == 1) im = $urandom();
        else                im = 32'($signed($urandom_range(0, 4095)) - 2048);
        if (f == 2 && pick > 1) im[0] = 1'b0;
        e = ref_err(f, im);
        send(f, 7'($urandom()), 3'($urandom()), 7'($urandom()), 5'($urandom()),
             5'($urandom()), 5'($urandom()), im, (k == n - 1));
        if (e != 0) break;
      end
      wait_finish();
      $display("[TB] random load %0d: %0d words expected, err %0d", ld, exp_q.size(), mdl_err);
      check_results("random", (mdl_err == 0) ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_wrap();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
